esc_mixer_pwm: RTL and testbench



---
 rtl/esc_mixer_pwm.sv | 186 ++++++++++++++++++
 tb/tb_esc_mixer_pwm.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_mixer_pwm.sv
// Purpose : quad-X motor mixer (thrust/roll/pitch/yaw -> 4 clamped duties) driving 4 PWM outputs,
//           with arming interlock, command watchdog/failsafe and period-aligned duty updates.
// Latency : accept at t -> duty_next at t+1 -> applied from the next PWM period start after t+1.
// Backpressure: cmd_ready_o is high in DISARMED/ARMED, low in FAILSAFE and while reset_i is high.
//
// Ports:
//   clk_i, reset_i (sync, active-high)      arm_i          level arming request
//   cmd_valid_i / cmd_ready_o               command handshake
//   thrust_i (unsigned), roll_i/pitch_i/yaw_i (signed two's complement), IN_W bits each
//   pwm_out_o[3:0]   registered PWM, bit i = motor i
//   period_start_o   one-cycle pulse aligned with the PWM output for counter==0
//   state_o          0=DISARMED, 1=ARMED, 2=FAILSAFE
//   sat_flags_o      per-motor clamp indication (only with MIXER_SAT_FLAG_EN, else 0)
//
// Optional feature macro: MIXER_SAT_FLAG_EN (adds clamp-detect flags).

module esc_mixer_pwm #(
    parameter int IN_W       = 8,
    parameter int PWM_W      = 10,
    parameter int WDT_CYCLES = 4096
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            arm_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [IN_W-1:0] thrust_i,
    input  logic [IN_W-1:0] roll_i,
    input  logic [IN_W-1:0] pitch_i,
    input  logic [IN_W-1:0] yaw_i,
    output logic [3:0]      pwm_out_o,
    output logic            period_start_o,
    output logic [1:0]      state_o,
    output logic [3:0]      sat_flags_o
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_e;

    // Three extra bits hold T +/- three signed terms without overflow.
    localparam int MW    = IN_W + 3;
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [PWM_W-1:0]       CNT_MAX = '1;
    localparam logic signed [MW-1:0]   MIX_MAX = MW'((1 << IN_W) - 1);
    localparam logic [WDT_W-1:0]       WDT_END = WDT_W'(WDT_CYCLES - 1);

    state_e                  state_q;
    logic [PWM_W-1:0]        cnt_q;
    logic [WDT_W-1:0]        wdt_q;
    logic                    tz_seen_q;
    logic [3:0][PWM_W-1:0]   duty_next_q;
    logic [3:0][PWM_W-1:0]   duty_active_q;
    logic [3:0]              pwm_q;
    logic                    period_start_q;

    logic                    accept_d;
    logic                    wdt_expire_d;
    logic                    leave_armed_d;
    logic signed [MW-1:0]    t_x, r_x, p_x, y_x;
    logic signed [MW-1:0]    mix_d [4];
    logic [IN_W-1:0]         clamp_d [4];
    logic [3:0][PWM_W-1:0]   duty_mix_d;

    assign cmd_ready_o = !reset_i && (state_q != ST_FAILSAFE);
    assign accept_d    = cmd_valid_i && cmd_ready_o;

    // Disarm takes priority: the watchdog only expires while arm_i is still held.
    assign wdt_expire_d  = (state_q == ST_ARMED) && arm_i && !accept_d && (wdt_q == WDT_END);
    assign leave_armed_d = (state_q == ST_ARMED) && (!arm_i || wdt_expire_d);

    always_comb begin
        t_x = {3'b000, thrust_i};
        r_x = {{3{roll_i[IN_W-1]}}, roll_i};
        p_x = {{3{pitch_i[IN_W-1]}}, pitch_i};
        y_x = {{3{yaw_i[IN_W-1]}}, yaw_i};
        mix_d[0] = t_x - r_x - p_x - y_x;
        mix_d[1] = t_x - r_x + p_x + y_x;
        mix_d[2] = t_x + r_x + p_x - y_x;
        mix_d[3] = t_x + r_x - p_x + y_x;
        for (int i = 0; i < 4; i++) begin
            if (mix_d[i][MW-1]) begin
                clamp_d[i] = '0;
            end else if (mix_d[i] > MIX_MAX) begin
                clamp_d[i] = '1;
            end else begin
                clamp_d[i] = mix_d[i][IN_W-1:0];
            end
            duty_mix_d[i] = PWM_W'(clamp_d[i]) << (PWM_W - IN_W);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_DISARMED;
            cnt_q          <= '0;
            wdt_q          <= '0;
            tz_seen_q      <= 1'b0;
            duty_next_q    <= '0;
            duty_active_q  <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_q + PWM_W'(1);
            period_start_q <= (cnt_q == '0);
            for (int i = 0; i < 4; i++) begin
                pwm_q[i] <= (state_q == ST_ARMED) && (cnt_q < duty_active_q[i]);
            end

            // Duty only changes at the period boundary so no output glitches.
            if (cnt_q == CNT_MAX) begin
                duty_active_q <= duty_next_q;
            end
            if (accept_d) begin
                tz_seen_q <= (thrust_i == '0);
            end
            if ((state_q == ST_ARMED) && accept_d) begin
                duty_next_q <= duty_mix_d;
            end

            case (state_q)
                ST_DISARMED: begin
                    if (arm_i && tz_seen_q) begin
                        state_q <= ST_ARMED;
                        wdt_q   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!arm_i) begin
                        state_q <= ST_DISARMED;
                    end else if (accept_d) begin
                        wdt_q <= '0;
                    end else if (wdt_expire_d) begin
                        state_q <= ST_FAILSAFE;
                    end else begin
                        wdt_q <= wdt_q + WDT_W'(1);
                    end
                end
                ST_FAILSAFE: begin
                    if (!arm_i) begin
                        state_q <= ST_DISARMED;
                    end
                end
                default: state_q <= ST_DISARMED;
            endcase

            // Later assignment overrides the load/mix above.
            if (leave_armed_d) begin
                duty_next_q   <= '0;
                duty_active_q <= '0;
            end
        end
    end

`ifdef MIXER_SAT_FLAG_EN
    logic [3:0] clip_d;
    logic [3:0] sat_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            clip_d[i] = mix_d[i][MW-1] || (mix_d[i] > MIX_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sat_q <= '0;
        end else if (leave_armed_d) begin
            sat_q <= '0;
        end else if ((state_q == ST_ARMED) && accept_d) begin
            sat_q <= clip_d;
        end
    end

    assign sat_flags_o = sat_q;
`else
    assign sat_flags_o = '0;
`endif

    assign pwm_out_o      = pwm_q;
    assign period_start_o = period_start_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_esc_mixer_pwm.sv
// Bench for esc_mixer_pwm: directed scenarios with literal expectations plus a randomized
// phase, all cycles checked against a behavioural model of the mixer/PWM rules.
module tb_esc_mixer_pwm;
    localparam int IN_W  = 8;
    localparam int PWM_W = 10;
    localparam int WDT   = 4096;
    localparam int PER   = 1 << PWM_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            arm = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [IN_W-1:0] thrust = '0, roll = '0, pitch = '0, yaw = '0;
    logic [3:0]      pwm_out;
    logic            period_start;
    logic [1:0]      state;
    logic [3:0]      sat_flags;

    esc_mixer_pwm #(.IN_W(IN_W), .PWM_W(PWM_W), .WDT_CYCLES(WDT)) dut (
        .clk_i(clk), .reset_i(reset), .arm_i(arm),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .thrust_i(thrust), .roll_i(roll), .pitch_i(pitch), .yaw_i(yaw),
        .pwm_out_o(pwm_out), .period_start_o(period_start),
        .state_o(state), .sat_flags_o(sat_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sx(input logic [IN_W-1:0] v);
        return (int'(v) >= (1 << (IN_W - 1))) ? int'(v) - (1 << IN_W) : int'(v);
    endfunction

    // Motor demand in PWM counts, from the quad-X mixing equations with clamping.
    function automatic int mix_duty(input int t, input int r, input int p, input int y,
                                    input int motor, output bit clipped);
        int m;
        case (motor)
            0:       m = t - r - p - y;
            1:       m = t - r + p + y;
            2:       m = t + r + p - y;
            default: m = t + r - p + y;
        endcase
        clipped = 1'b0;
        if (m < 0) begin
            m = 0; clipped = 1'b1;
        end else if (m > (1 << IN_W) - 1) begin
            m = (1 << IN_W) - 1; clipped = 1'b1;
        end
        return m * (1 << (PWM_W - IN_W));
    endfunction

    int         m_state = 0, m_cnt = 0, m_tz = 0, m_idle = 0;
    int         m_next[4], m_act[4];
    logic [3:0] m_pwm = '0, m_sat = '0;
    logic       m_ps = 1'b0;
    bit         started = 1'b0;

    task automatic m_leave(input int to);
        m_state = to;
        for (int i = 0; i < 4; i++) begin
            m_next[i] = 0;
            m_act[i]  = 0;
        end
        m_sat = '0;
    endtask

    always @(posedge clk) begin : model
        bit acc, clip;
        int old_state, old_tz;
        started = 1'b1;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_tz = 0; m_idle = 0;
            m_pwm = '0; m_sat = '0; m_ps = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_next[i] = 0; m_act[i] = 0;
            end
        end else begin
            acc       = cmd_valid && (m_state != 2);
            old_state = m_state;
            old_tz    = m_tz;
            m_ps      = (m_cnt == 0);
            for (int i = 0; i < 4; i++) m_pwm[i] = (old_state == 1) && (m_cnt < m_act[i]);
            if (m_cnt == PER - 1) for (int i = 0; i < 4; i++) m_act[i] = m_next[i];
            if (old_state == 1 && acc) begin
                for (int i = 0; i < 4; i++) begin
                    m_next[i] = mix_duty(int'(thrust), sx(roll), sx(pitch), sx(yaw), i, clip);
                    m_sat[i]  = clip;
                end
            end
            if (acc) m_tz = (thrust == 0);
            case (old_state)
                0: if (arm && old_tz != 0) begin m_state = 1; m_idle = 0; end
                1: begin
                    if (!arm) m_leave(0);
                    else if (acc) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == WDT) m_leave(2);
                    end
                end
                default: if (!arm) m_state = 0;
            endcase
            m_cnt = (m_cnt + 1) % PER;
        end
    end

    // One compare process: every cycle, outputs vs model.
    always @(negedge clk) begin
        logic [3:0] exp_sat;
        if (started) begin
`ifdef MIXER_SAT_FLAG_EN
            exp_sat = m_sat;
`else
            exp_sat = 4'b0000;
`endif
            chk("cmp_state", state, m_state);
            chk("cmp_cmd_ready", cmd_ready, (!reset && m_state != 2) ? 1 : 0);
            chk("cmp_pwm_out", pwm_out, m_pwm);
            chk("cmp_period_start", period_start, m_ps);
            chk("cmp_sat_flags", sat_flags, exp_sat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int t, input int r, input int p, input int y);
        thrust = IN_W'(t); roll = IN_W'(r); pitch = IN_W'(p); yaw = IN_W'(y);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2 * PER + 8; k++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_period_start", 0, 1);
    endtask

    int hi[4];
    // Counts high cycles per motor over one full period, starting at a period_start negedge.
    task automatic measure();
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int k = 0; k < PER; k++) begin
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit c;
        bit found;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_pwm", pwm_out, 0);
        chk("reset_period_start", period_start, 0);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_sat", sat_flags, 0);
        // Pin the model's mixer to hand-computed values.
        chk("model_mix_m0", mix_duty(250, 100, 0, 0, 0, c), 600);
        chk("model_mix_m2", mix_duty(250, 100, 0, 0, 2, c), 1020);
        chk("model_mix_low", mix_duty(10, 0, 0, 50, 0, c), 0);
        tick();
        reset = 1'b0;

        // Arm and drive
        send(0, 0, 0, 0);
        arm = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("arm_state", state, 1);
        send(128, 0, 0, 0);
        wait_ps();
        measure();
        for (int i = 0; i < 4; i++) chk("drive_high_cycles", hi[i], 512);

        // Saturation
        send(250, 100, 0, 0);
        wait_ps();
        measure();
        chk("sat_m0", hi[0], 600);
        chk("sat_m1", hi[1], 600);
        chk("sat_m2", hi[2], 1020);
        chk("sat_m3", hi[3], 1020);
`ifdef MIXER_SAT_FLAG_EN
        chk("sat_flags_lit", sat_flags, 4'b1100);
`else
        chk("sat_flags_lit", sat_flags, 4'b0000);
`endif

        // Watchdog
        found = 1'b0;
        for (int k = 0; k < WDT + 50; k++) begin
            @(negedge clk);
            if (state == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("wdt_fired", found, 1);
        chk("wdt_state", state, 2);
        chk("wdt_ready", cmd_ready, 0);
        @(negedge clk);
        chk("wdt_pwm", pwm_out, 0);
        tick();
        arm = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("failsafe_disarm", state, 0);

        // Arm interlock
        tick();
        arm = 1'b1;
        send(40, 0, 0, 0);
        repeat (4) tick();
        @(negedge clk);
        chk("interlock_state", state, 0);
        chk("interlock_pwm", pwm_out, 0);
        send(0, 0, 0, 0);
        @(negedge clk);
        chk("interlock_same_cycle", state, 0);
        tick();
        @(negedge clk);
        chk("interlock_armed_next", state, 1);

        // Period alignment: accept on the counter==PER-1 cycle
        send(128, 0, 0, 0);
        wait_ps();
        measure();
        repeat (PER - 2) tick();
        send(64, 0, 0, 0);
        wait_ps();
        measure();
        chk("align_old_duty", hi[0], 512);
        measure();
        chk("align_new_duty", hi[0], 256);

        // Reset mid-operation at counter 300 with duty 512
        send(128, 0, 0, 0);
        wait_ps();
        measure();
        repeat (299) tick();
        @(negedge clk);
        chk("midreset_pre_pwm", pwm_out, 4'hF);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("midreset_pwm", pwm_out, 0);
        chk("midreset_state", state, 0);
        chk("midreset_ps", period_start, 0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("midreset_counter_restart", period_start, 1);

        // Randomized phase
        for (int n = 0; n < 20000; n++) begin
            tick();
            reset = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 399) == 0) arm = ~arm;
            cmd_valid = ($urandom_range(0, 3) == 0);
            thrust    = ($urandom_range(0, 4) == 0) ? '0 : IN_W'($urandom);
            roll      = IN_W'($urandom);
            pitch     = IN_W'($urandom_range(0, 40));
            yaw       = IN_W'($urandom);
        end
        tick();
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
